// File: rtl/pc_next_ctrl.sv
// Next-PC sequencer feeding the PC register.
// Issues a write into the PC register, waits out its commit latency, then
// offers the committed PC to fetch over valid/ready. Branch/jump redirects
// are latched as a pending target and override the sequential PC+4 flow.
module pc_next_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned COMMIT_LAT = 4
) (
    input  logic        clk_i,
    input  logic        i_rst,
    input  logic        en_i,
    input  logic [31:0] pc_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    input  logic        fetch_ready_i,
    output logic        pc_we_o,
    output logic [31:0] pc_next_o,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_pc_o,
    output logic        misalign_o,
    output logic        busy_o
);

    // wait_cnt runs 0..COMMIT_LAT-2; a latency of 2 still needs one bit.
    localparam int unsigned CNT_W = (COMMIT_LAT > 2) ? $clog2(COMMIT_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(COMMIT_LAT - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FETCH = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            pending_vld_q;
    logic [31:0]     pending_tgt_q;
    logic [31:0]     next_pc_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic            misalign_q;

    logic            redir_ok;
    logic            redir_bad;
    logic            wait_done;
    logic            offer;
    logic            handshake;

    // Classify the redirect request and derive the per-cycle handshake terms.
    always_comb begin
        redir_ok  = redirect_valid_i & (redirect_target_i[1:0] == 2'b00);
        redir_bad = redirect_valid_i & (redirect_target_i[1:0] != 2'b00);
        wait_done = (state_q == WAIT) && (wait_cnt_q == WAIT_LAST);
        // Any redirect request in FETCH withdraws the offer for that cycle.
        offer     = (state_q == FETCH) & ~redirect_valid_i;
        handshake = offer & fetch_ready_i;
    end

    // State register.
    always_ff @(posedge clk_i or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // The full commit latency is always waited out, so two writes are
                // never closer than COMMIT_LAT cycles. A redirect arriving on the
                // last wait cycle counts as pending so the stale PC is not offered.
                if (wait_done) begin
                    if (pending_vld_q || redir_ok) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (redir_ok) begin
                    state_d = ISSUE;
                end else if (handshake) begin
                    state_d = en_i ? ISSUE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending redirect: latest aligned redirect wins; an issue consumes it unless
    // a new redirect lands in the same cycle.
    always_ff @(posedge clk_i or negedge i_rst) begin
        if (!i_rst) begin
            pending_vld_q <= 1'b0;
            pending_tgt_q <= '0;
        end else if (redir_ok) begin
            pending_vld_q <= 1'b1;
            pending_tgt_q <= redirect_target_i;
        end else if (state_q == ISSUE) begin
            pending_vld_q <= 1'b0;
        end
    end

    // Sequential next PC: advances past each PC that fetch accepts.
    always_ff @(posedge clk_i or negedge i_rst) begin
        if (!i_rst) begin
            next_pc_q <= RESET_PC;
        end else if (handshake) begin
            next_pc_q <= pc_i + 32'd4;
        end
    end

    // Commit-latency counter, active only while in WAIT.
    always_ff @(posedge clk_i or negedge i_rst) begin
        if (!i_rst) begin
            wait_cnt_q <= '0;
        end else if ((state_q == WAIT) && !wait_done) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_q <= '0;
        end
    end

    // Misaligned redirect flag, reported one cycle after the request.
    always_ff @(posedge clk_i or negedge i_rst) begin
        if (!i_rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redir_bad;
        end
    end

    // Output decode.
    always_comb begin
        pc_we_o       = (state_q == ISSUE);
        pc_next_o     = pending_vld_q ? pending_tgt_q : next_pc_q;
        fetch_valid_o = offer;
        fetch_pc_o    = (state_q == FETCH) ? pc_i : '0;
        misalign_o    = misalign_q;
        busy_o        = (state_q != IDLE);
    end

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Bench for pc_next_ctrl: cycle table for the main flow, hand sequences for
// mid-operation reset and PC wrap. Includes a behavioural PC register.
module tb_pc_next_ctrl;

    localparam int unsigned LAT = 4;
    localparam int unsigned D   = LAT - 1;

    logic        clk_i = 1'b0;
    logic        i_rst;
    logic        en_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_target_i;
    logic        fetch_ready_i;
    logic [31:0] pc_i;
    logic        pc_we_o;
    logic [31:0] pc_next_o;
    logic        fetch_valid_o;
    logic [31:0] fetch_pc_o;
    logic        misalign_o;
    logic        busy_o;

    // Second instance for the wrap case.
    logic        en_w;
    logic [31:0] pc_w;
    logic        we_w;
    logic [31:0] next_w;
    logic        fv_w;
    logic [31:0] fpc_w;
    logic        mis_w;
    logic        busy_w;

    always #5 clk_i = ~clk_i;

    pc_next_ctrl #(.RESET_PC(32'h0000_0000), .COMMIT_LAT(LAT)) dut (
        .clk_i(clk_i), .i_rst(i_rst), .en_i(en_i), .pc_i(pc_i),
        .redirect_valid_i(redirect_valid_i), .redirect_target_i(redirect_target_i),
        .fetch_ready_i(fetch_ready_i), .pc_we_o(pc_we_o), .pc_next_o(pc_next_o),
        .fetch_valid_o(fetch_valid_o), .fetch_pc_o(fetch_pc_o),
        .misalign_o(misalign_o), .busy_o(busy_o)
    );

    pc_next_ctrl #(.RESET_PC(32'hFFFF_FFFC), .COMMIT_LAT(LAT)) dut_w (
        .clk_i(clk_i), .i_rst(i_rst), .en_i(en_w), .pc_i(pc_w),
        .redirect_valid_i(1'b0), .redirect_target_i(32'h0),
        .fetch_ready_i(1'b1), .pc_we_o(we_w), .pc_next_o(next_w),
        .fetch_valid_o(fv_w), .fetch_pc_o(fpc_w),
        .misalign_o(mis_w), .busy_o(busy_w)
    );

    // PC register model: a write shows on pc at the edge ending cycle t+LAT-1.
    logic        pv_m [D];
    logic [31:0] pd_m [D];
    logic        pv_w [D];
    logic [31:0] pd_w [D];

    always @(posedge clk_i or negedge i_rst) begin
        if (!i_rst) begin
            for (int k = 0; k < D; k++) begin
                pv_m[k] <= 1'b0;
                pv_w[k] <= 1'b0;
                pd_m[k] <= 32'h0;
                pd_w[k] <= 32'h0;
            end
            pc_i <= 32'hDEAD_BEE0;
            pc_w <= 32'hDEAD_BEE0;
        end else begin
            pv_m[0] <= pc_we_o;
            pd_m[0] <= pc_next_o;
            pv_w[0] <= we_w;
            pd_w[0] <= next_w;
            for (int k = 1; k < D; k++) begin
                pv_m[k] <= pv_m[k-1];
                pd_m[k] <= pd_m[k-1];
                pv_w[k] <= pv_w[k-1];
                pd_w[k] <= pd_w[k-1];
            end
            if (pv_m[D-1]) pc_i <= pd_m[D-1];
            if (pv_w[D-1]) pc_w <= pd_w[D-1];
        end
    end

    typedef struct {
        logic        en;
        logic        rdy;
        logic        rv;
        logic [31:0] rt;
        logic        we;
        logic [31:0] nxt;
        logic        fv;
        logic [31:0] fpc;
        logic        mis;
        logic        busy;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void add(input logic en, input logic rdy, input logic rv,
                                input logic [31:0] rt, input logic we, input logic [31:0] nxt,
                                input logic fv, input logic [31:0] fpc, input logic mis,
                                input logic busy);
        vec_t v;
        v.en = en; v.rdy = rdy; v.rv = rv; v.rt = rt; v.we = we; v.nxt = nxt;
        v.fv = fv; v.fpc = fpc; v.mis = mis; v.busy = busy;
        tbl.push_back(v);
    endfunction

    // n plain WAIT cycles
    function automatic void add_wait(input int n, input logic en);
        for (int i = 0; i < n; i++) add(en, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1);
    endfunction

    initial begin
        vec_t v;
        vec_t e;
        bit   found;
        int   lat;

        i_rst = 1'b0;
        en_i = 1'b0; en_w = 1'b0;
        redirect_valid_i = 1'b0; redirect_target_i = 32'h0; fetch_ready_i = 1'b0;

        //      en rdy rv target        we next         fv fpc           mis busy
        add(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        0, 0); // c0 IDLE
        add(1, 0, 0, 32'h0,          1, 32'h0,        0, 32'h0,        0, 1); // c1 ISSUE 0
        add_wait(3, 1);
        add(1, 1, 0, 32'h0,          0, 32'h0,        1, 32'h0,        0, 1); // c5 FETCH 0
        add(1, 0, 0, 32'h0,          1, 32'h4,        0, 32'h0,        0, 1); // c6 ISSUE 4
        add_wait(3, 1);
        add(1, 1, 0, 32'h0,          0, 32'h0,        1, 32'h4,        0, 1); // c10 FETCH 4
        add(1, 0, 0, 32'h0,          1, 32'h8,        0, 32'h0,        0, 1); // c11 ISSUE 8
        add_wait(3, 1);
        add(1, 1, 0, 32'h0,          0, 32'h0,        1, 32'h8,        0, 1); // c15 FETCH 8
        add(1, 0, 0, 32'h0,          1, 32'hC,        0, 32'h0,        0, 1); // c16 ISSUE C
        add(1, 0, 1, 32'h100,        0, 32'h0,        0, 32'h0,        0, 1); // c17 redirect in WAIT
        add_wait(2, 1);
        add(1, 0, 0, 32'h0,          1, 32'h100,      0, 32'h0,        0, 1); // c20 ISSUE 100
        add_wait(3, 1);
        add(1, 1, 1, 32'h200,        0, 32'h0,        0, 32'h0,        0, 1); // c24 redirect in FETCH
        add(1, 0, 0, 32'h0,          1, 32'h200,      0, 32'h0,        0, 1); // c25 ISSUE 200
        add_wait(3, 1);
        add(1, 1, 0, 32'h0,          0, 32'h0,        1, 32'h200,      0, 1); // c29 FETCH 200
        add(1, 0, 0, 32'h0,          1, 32'h204,      0, 32'h0,        0, 1); // c30 ISSUE 204
        add(1, 0, 1, 32'h300,        0, 32'h0,        0, 32'h0,        0, 1); // c31
        add(1, 0, 1, 32'h400,        0, 32'h0,        0, 32'h0,        0, 1); // c32 latest wins
        add(1, 0, 1, 32'h302,        0, 32'h0,        0, 32'h0,        0, 1); // c33 misaligned
        add(0, 0, 0, 32'h0,          1, 32'h400,      0, 32'h0,        1, 1); // c34 ISSUE 400
        add_wait(3, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 32'h0,      0, 32'h0,        1, 32'h400,      0, 1); // c38-42 stall
        add(0, 1, 0, 32'h0,          0, 32'h0,        1, 32'h400,      0, 1); // c43 accept, en=0
        add(0, 0, 1, 32'h302,        0, 32'h0,        0, 32'h0,        0, 0); // c44 IDLE misaligned
        add(0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        1, 0); // c45 still IDLE
        add(1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        0, 0); // c46 IDLE en
        add(1, 0, 1, 32'h500,        1, 32'h404,      0, 32'h0,        0, 1); // c47 ISSUE 404

        // Reset state.
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst we", pc_we_o, 0);
        chk("rst next", pc_next_o, 32'h0);
        chk("rst fv", fetch_valid_o, 0);
        chk("rst fpc", fetch_pc_o, 32'h0);
        chk("rst mis", misalign_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst next_w", next_w, 32'hFFFF_FFFC);
        i_rst = 1'b1;

        // Table: drive, push expectation, compare at the falling edge.
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            en_i = v.en; fetch_ready_i = v.rdy;
            redirect_valid_i = v.rv; redirect_target_i = v.rt;
            exp_q.push_back(v);
            @(negedge clk_i);
            e = exp_q.pop_front();
            chk($sformatf("c%0d we", i), pc_we_o, e.we);
            if (e.we) chk($sformatf("c%0d next", i), pc_next_o, e.nxt);
            chk($sformatf("c%0d fv", i), fetch_valid_o, e.fv);
            if (e.fv) chk($sformatf("c%0d fpc", i), fetch_pc_o, e.fpc);
            chk($sformatf("c%0d mis", i), misalign_o, e.mis);
            chk($sformatf("c%0d busy", i), busy_o, e.busy);
            @(posedge clk_i);
            #1;
        end

        // Async reset in WAIT with a pending redirect to 0x500.
        en_i = 1'b0; redirect_valid_i = 1'b0; fetch_ready_i = 1'b1;
        chk("pre-rst busy", busy_o, 1);
        #1 i_rst = 1'b0;
        #1;
        chk("mid-rst busy", busy_o, 0);
        chk("mid-rst we", pc_we_o, 0);
        chk("mid-rst fv", fetch_valid_o, 0);
        chk("mid-rst next", pc_next_o, 32'h0);
        @(posedge clk_i);
        #1 i_rst = 1'b1; en_i = 1'b1;
        found = 0; lat = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk_i);
            if (pc_we_o) begin found = 1; lat = i; end
        end
        chk("restart issue seen", found, 1);
        chk("restart latency", lat, 1);
        chk("restart pc", pc_next_o, 32'h0);
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk_i);
            if (fetch_valid_o) found = 1;
        end
        chk("restart fetch seen", found, 1);
        chk("restart fpc", fetch_pc_o, 32'h0);

        // Wrap: RESET_PC = FFFF_FFFC, next sequential PC is 0.
        @(posedge clk_i);
        #1 en_w = 1'b1; en_i = 1'b0;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk_i);
            if (we_w) found = 1;
        end
        chk("wrap issue seen", found, 1);
        chk("wrap first pc", next_w, 32'hFFFF_FFFC);
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk_i);
            if (fv_w) found = 1;
        end
        chk("wrap fetch seen", found, 1);
        chk("wrap fpc", fpc_w, 32'hFFFF_FFFC);
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk_i);
            if (we_w) found = 1;
        end
        chk("wrap second issue seen", found, 1);
        chk("wrap second pc", next_w, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
